gb_host_bridge: RTL and testbench

Byte-stream host bridge that drives the ghostbus from the upstream side. It parses framed read/write commands arriving on a byte interface with valid/ready handshaking. Each command becomes one single-beat ghostbus transaction on `gb_addr`/`gb_dout`/`gb_we`/`gb_din`, and the bridge streams the response bytes back. It sits between the host link (UART/packet decoder) and the top of the auto-decoded ghostbus tree, and is the only bus master on that tree.

---
 rtl/gb_host_bridge.sv | 182 ++++++++++++++++++
 tb/tb_gb_host_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_host_bridge.sv
// Byte-stream host bridge: parses read/write command frames, issues one ghostbus
// transaction per frame and streams the response bytes back to the host.
module gb_host_bridge #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic          busy,
    output logic [15:0]   txn_count
);
    localparam int unsigned NB       = DW / 8;
    localparam logic [3:0]  LastData = 4'(NB - 1);
    localparam logic [3:0]  LastLat  = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StWdata, StWstb, StRwait, StResp, StErr
    } state_e;

    state_e        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_dout_q, gb_dout_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   txn_count_q, txn_count_d;
    logic          busy_q;

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        gb_addr_d   = gb_addr_q;
        gb_dout_d   = gb_dout_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        txn_count_d = txn_count_q;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = !rst;
                if (in_valid) begin
                    if (in_data == 8'h01 || in_data == 8'h02) begin
                        state_d = StAddr;
                        is_wr_d = (in_data == 8'h01);
                        cnt_d   = 4'd0;
                    end else begin
                        state_d     = StErr;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'hEE;
                    end
                end
            end
            StAddr: begin
                in_ready = !rst;
                if (in_valid) begin
                    if (cnt_q == 4'd0) begin
                        addr_d = AW'(in_data);
                        cnt_d  = 4'd1;
                    end else begin
                        // Truncation drops the address bits above AW.
                        addr_d = AW'({addr_q, in_data});
                        cnt_d  = 4'd0;
                        if (is_wr_q) begin
                            state_d = StWdata;
                        end else begin
                            gb_addr_d = AW'({addr_q, in_data});
                            state_d   = StRwait;
                        end
                    end
                end
            end
            StWdata: begin
                in_ready = !rst;
                if (in_valid) begin
                    data_d = DW'({data_q, in_data});
                    if (cnt_q == LastData) begin
                        gb_addr_d = addr_q;
                        gb_dout_d = DW'({data_q, in_data});
                        cnt_d     = 4'd0;
                        state_d   = StWstb;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StWstb: begin
                state_d     = StResp;
                out_valid_d = 1'b1;
                out_data_d  = 8'hA5;
                cnt_d       = 4'd0;
            end
            StRwait: begin
                if (cnt_q == LastLat) begin
                    out_valid_d = 1'b1;
                    out_data_d  = gb_din[DW-1 -: 8];
                    data_d      = gb_din << 8;
                    cnt_d       = LastData;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                // cnt_q holds the number of bytes still to follow the one on out_data.
                if (out_ready) begin
                    if (cnt_q == 4'd0) begin
                        out_valid_d = 1'b0;
                        txn_count_d = txn_count_q + 16'd1;
                        state_d     = StIdle;
                    end else begin
                        out_data_d = data_q[DW-1 -: 8];
                        data_d     = data_q << 8;
                        cnt_d      = cnt_q - 4'd1;
                    end
                end
            end
            StErr: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            data_q      <= '0;
            gb_addr_q   <= '0;
            gb_dout_q   <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            txn_count_q <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gb_addr_q   <= gb_addr_d;
            gb_dout_q   <= gb_dout_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            txn_count_q <= txn_count_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    // Gated by rst so a reset landing in the strobe cycle suppresses the write.
    assign gb_we     = (state_q == StWstb) && !rst;
    assign gb_addr   = gb_addr_q;
    assign gb_dout   = gb_dout_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign txn_count = txn_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Scoreboard bench for gb_host_bridge: stimulus pushes expected bus writes and response
// bytes into queues; independent monitors pop and compare as the DUT produces them.
module tb_gb_host_bridge;
    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic [DW-1:0] gb_din;
    logic          gb_we;
    logic          busy;
    logic [15:0]   txn_count;

    int            n_checks;
    int            n_fail;
    logic [15:0]   exp_txn;
    bit            stall;
    bit            rd_last;
    logic [AW-1:0] rd_addr;
    int            lat;
    int            lat_nxt;

    logic [7:0]         q_resp [$];
    logic [AW+DW-1:0]   q_wr [$];
    logic [31:0]        ref_mem [4096];
    bit                 ref_wr [4096];
    logic [31:0]        bus_mem [4096];
    bit                 bus_wr [4096];

    gb_host_bridge #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gb_addr   (gb_addr),
        .gb_dout   (gb_dout),
        .gb_din    (gb_din),
        .gb_we     (gb_we),
        .busy      (busy),
        .txn_count (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Background bus contents; 0x010 holds the pattern used by the directed read.
    function automatic logic [31:0] def_val(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hCECEFACE;
        return 32'hA5C30000 ^ ({20'h0, a} * 32'h9E3779B1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h, required no such event", name, act);
    endtask

    // Bus model: read data is valid only in the single cycle RD_LAT after the address.
    always_comb begin
        if (rst) lat_nxt = 0;
        else if (in_valid && in_ready && rd_last) lat_nxt = 1;
        else if (lat != 0 && lat < 15) lat_nxt = lat + 1;
        else lat_nxt = lat;
    end

    always @(posedge clk) begin
        lat    <= lat_nxt;
        gb_din <= (lat_nxt == RD_LAT) ?
                  (bus_wr[rd_addr] ? bus_mem[rd_addr] : def_val(rd_addr)) : 32'hBAD0BAD0;
        if (gb_we) begin
            bus_mem[gb_addr] <= gb_dout;
            bus_wr[gb_addr]  <= 1'b1;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Response monitor: byte order, no loss/duplication, stability under stall.
    initial begin : resp_mon
        logic [7:0] held;
        logic [7:0] e;
        bit         have_held;
        have_held = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_held = 1'b0;
            end else begin
                if (out_valid && have_held) check("out_hold", out_data, held);
                if (out_valid && out_ready) begin
                    if (q_resp.size() == 0) begin
                        fail_now("resp_extra", out_data);
                    end else begin
                        e = q_resp.pop_front();
                        check("resp_byte", out_data, e);
                    end
                    have_held = 1'b0;
                end else if (out_valid) begin
                    held = out_data;
                    have_held = 1'b1;
                end else begin
                    have_held = 1'b0;
                end
            end
        end
    end

    // Bus monitor: every strobe matches an expected write; read address in the data window.
    initial begin : bus_mon
        logic [AW+DW-1:0] w;
        bit prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (gb_we) begin
                if (prev_we) fail_now("we_width", 32'(gb_addr));
                if (q_wr.size() == 0) begin
                    fail_now("we_extra", 32'(gb_addr));
                end else begin
                    w = q_wr.pop_front();
                    check("wr_addr", 32'(gb_addr), 32'(w[AW+DW-1:DW]));
                    check("wr_data", gb_dout, w[DW-1:0]);
                end
            end
            if (lat == RD_LAT) check("rd_addr", 32'(gb_addr), 32'(rd_addr));
            prev_we = gb_we;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last_rd, input bit gaps);
        bit acc;
        int g;
        g = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_data = b;
        in_valid = 1'b1;
        rd_last = last_rd;
        acc = 1'b0;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rd_last = 1'b0;
        if (!acc) fail_now("in_timeout", 32'(b));
    endtask

    task automatic do_frame(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                            input bit gaps);
        logic [AW-1:0] am;
        logic [31:0]   v;
        am = a[AW-1:0];
        if (op == 8'h01) begin
            q_wr.push_back({am, d});
            ref_mem[am] = d;
            ref_wr[am] = 1'b1;
            q_resp.push_back(8'hA5);
            exp_txn = exp_txn + 16'd1;
            send_byte(op, 1'b0, gaps);
            send_byte(a[15:8], 1'b0, gaps);
            send_byte(a[7:0], 1'b0, gaps);
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b0, gaps);
        end else if (op == 8'h02) begin
            v = ref_wr[am] ? ref_mem[am] : def_val(am);
            for (int i = 3; i >= 0; i--) q_resp.push_back(v[8*i +: 8]);
            exp_txn = exp_txn + 16'd1;
            send_byte(op, 1'b0, gaps);
            send_byte(a[15:8], 1'b0, gaps);
            rd_addr = am;
            send_byte(a[7:0], 1'b1, gaps);
        end else begin
            q_resp.push_back(8'hEE);
            send_byte(op, 1'b0, gaps);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            done = (q_resp.size() == 0) && !busy;
        end
        if (!done) fail_now("idle_timeout", 32'(busy));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0]  op;
        logic [15:0] a16;
        logic [7:0]  bad_ops [4];
        int          r;
        bad_ops = '{8'h00, 8'h03, 8'h7F, 8'hFF};
        n_checks = 0;
        n_fail = 0;
        in_data = 8'h00;
        in_valid = 1'b0;
        rd_last = 1'b0;
        rd_addr = '0;
        stall = 1'b0;
        exp_txn = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_gb_we", 32'(gb_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_txn", 32'(txn_count), 0);
        check("rst_gb_addr", 32'(gb_addr), 0);
        check("rst_gb_dout", gb_dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write 01 01 23 DE AD BE EF: strobe in N+1, ack from N+2.
        do_frame(8'h01, 16'h0123, 32'hDEADBEEF, 1'b0);
        check("w_we_n1", 32'(gb_we), 1);
        check("w_addr_n1", 32'(gb_addr), 32'h123);
        check("w_dout_n1", gb_dout, 32'hDEADBEEF);
        check("w_ov_n1", 32'(out_valid), 0);
        check("w_busy_n1", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("w_we_n2", 32'(gb_we), 0);
        check("w_ov_n2", 32'(out_valid), 1);
        check("w_ack_n2", 32'(out_data), 32'hA5);
        wait_idle();
        check("w_txn", 32'(txn_count), 1);

        // Read 02 00 10: first byte at N+3, one byte per cycle, in_ready right after.
        do_frame(8'h02, 16'h0010, 32'h0, 1'b0);
        check("r_ov_n1", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("r_ov_n2", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("r_ov_n3", 32'(out_valid), 1);
        check("r_byte0_n3", 32'(out_data), 32'hCE);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("r_ov_n6", 32'(out_valid), 1);
        check("r_inrdy_n6", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("r_inrdy_n7", 32'(in_ready), 1);
        check("r_busy_n7", 32'(busy), 0);
        check("r_txn", 32'(txn_count), 2);

        // Bad opcode, then bad opcode followed back-to-back by fresh frames.
        do_frame(8'h7F, 16'h0, 32'h0, 1'b0);
        wait_idle();
        check("err_txn", 32'(txn_count), 2);
        do_frame(8'h00, 16'h0, 32'h0, 1'b0);
        do_frame(8'h01, 16'hF005, 32'h11223344, 1'b0);
        do_frame(8'h02, 16'h3005, 32'h0, 1'b0);
        wait_idle();
        check("err_fresh_txn", 32'(txn_count), 32'(exp_txn));

        // Mixed frames with input gaps and output stalls.
        stall = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom);
            a16[11:4] = 8'h00;
            r = int'($urandom_range(0, 19));
            if (r < 9) op = 8'h01;
            else if (r < 18) op = 8'h02;
            else op = bad_ops[$urandom_range(0, 3)];
            do_frame(op, a16, $urandom, 1'b1);
        end
        wait_idle();
        stall = 1'b0;
        check("mix_txn", 32'(txn_count), 32'(exp_txn));

        // Reset after 3 of 7 write bytes: frame discarded, outputs cleared.
        do_frame(8'h01, 16'h000C, 32'h12345678, 1'b0);
        wait_idle();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        send_byte(8'hBC, 1'b0, 1'b0);
        rst = 1'b1;
        exp_txn = 16'h0000;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_gb_addr", 32'(gb_addr), 0);
        check("mid_rst_gb_dout", gb_dout, 0);
        check("mid_rst_gb_we", 32'(gb_we), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_txn", 32'(txn_count), 0);
        do_frame(8'h02, 16'h0ABC, 32'h0, 1'b0);
        wait_idle();
        check("post_rst_txn", 32'(txn_count), 1);

        // Counter wrap from 0xFFFF.
        force dut.txn_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.txn_count_q;
        exp_txn = 16'hFFFF;
        @(posedge clk);
        #1;
        do_frame(8'h01, 16'h0007, 32'hCAFEF00D, 1'b0);
        wait_idle();
        check("txn_wrap", 32'(txn_count), 32'(exp_txn));

        check("resp_q_empty", q_resp.size(), 0);
        check("wr_q_empty", q_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
